// File: rtl/mem_store_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_store_buffer_if : pipeline/dmem bundle around the store buffer       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface mem_store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic [1:0]    st_size;
  logic          st_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_stall;
  logic          drain_req;
  logic          busy;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [1:0]    dm_store;

  modport master (
    output st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, drain_req,
    input  st_ready, ld_stall, busy, dm_we, dm_addr, dm_wdata, dm_store
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, drain_req,
    output st_ready, ld_stall, busy, dm_we, dm_addr, dm_wdata, dm_store
  );
endinterface
`default_nettype wire

// File: rtl/mem_store_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_store_buffer : FIFO write buffer between EX/MEM and dmem with        |
// |                    load-after-store word-address hazard stall            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  mem_store_buffer_if.slave  bus
);
  localparam int            PW     = $clog2(DEPTH);
  localparam logic [PW:0]   c_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   c_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] c_PONE = {{(PW-1){1'b0}}, 1'b1};

  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [1:0]       r_size [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW:0]      r_count;

  logic [DEPTH-1:0] w_hit;
  logic             w_ld_hit;
  logic             w_nonempty;
  logic             w_push;
  logic             w_drain;

  // Word-granular compare only; the entry being pushed this cycle is not yet valid.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign w_hit[i] = r_valid[i] && (r_addr[i][AW-1:2] == bus.ld_addr[AW-1:2]);
  end

  assign w_ld_hit   = bus.ld_valid && (|w_hit);
  assign w_nonempty = (r_count != '0);
  assign w_push     = rst_n && bus.st_valid && (r_count != c_FULL);
  // A stalled load leaves the port free, so draining under it avoids deadlock.
  assign w_drain    = rst_n && w_nonempty && (!bus.ld_valid || w_ld_hit || bus.drain_req);

  assign bus.st_ready = rst_n && (r_count != c_FULL);
  assign bus.ld_stall = rst_n && w_ld_hit;
  assign bus.busy     = rst_n && w_nonempty;
  assign bus.dm_we    = w_drain;
  assign bus.dm_addr  = r_addr[r_head];
  assign bus.dm_wdata = r_data[r_head];
  assign bus.dm_store = r_size[r_head];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.st_addr;
      r_data[r_tail] <= bus.st_data;
      r_size[r_tail] <= bus.st_size;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + c_PONE;
      end
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + c_PONE;
      end
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + c_ONE;
        2'b01:   r_count <= r_count - c_ONE;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_store_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_store_buffer : directed self-checking bench for mem_store_buffer  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mem_store_buffer;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  logic allow_dual;

  mem_store_buffer_if #(.AW(32), .DW(32)) bus ();

  mem_store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fill-style tests hold a non-matching load to keep the port busy while pushing.
  always @(negedge clk) begin
    if (rst_n && !allow_dual)
      assert (!(bus.st_valid && bus.ld_valid))
        else $error("illegal st_valid && ld_valid in same cycle");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    bus.st_valid  = 1'b0;
    bus.st_addr   = '0;
    bus.st_data   = '0;
    bus.st_size   = 2'b00;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = '0;
    bus.drain_req = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_size  = s;
  endtask

  task automatic chk_wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s);
    chk({tag, ".we"},   64'(bus.dm_we), 64'd1);
    chk({tag, ".addr"}, 64'(bus.dm_addr), 64'(a));
    chk({tag, ".data"}, 64'(bus.dm_wdata), 64'(d));
    chk({tag, ".size"}, 64'(bus.dm_store), 64'(s));
  endtask

  // Back-to-back stores with no loads: each drains exactly one cycle after push.
  task automatic stream(input string tag, input int n, input logic [31:0] abase,
                        input logic [31:0] dbase, input logic [1:0] s);
    for (int k = 0; k <= n; k++) begin
      bus.ld_valid = 1'b0;
      if (k < n) store(abase + 32'(4 * k), dbase + 32'(k), s);
      else       bus.st_valid = 1'b0;
      settle();
      if (k == 0) begin
        chk({tag, ".first_we"}, 64'(bus.dm_we), 64'd0);
      end else begin
        chk_wr($sformatf("%s.w%0d", tag, k - 1), abase + 32'(4 * (k - 1)),
               dbase + 32'(k - 1), s);
        chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
      end
      if (k < n) chk({tag, ".ready"}, 64'(bus.st_ready), 64'd1);
      tick();
    end
    idle();
    settle();
    chk({tag, ".empty"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic buffer3(input logic [31:0] abase);
    allow_dual   = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h400;
    for (int i = 0; i < 3; i++) begin
      store(abase + 32'(4 * i), 32'h7000 + 32'(i), 2'b00);
      settle();
      chk("fence.push_we", 64'(bus.dm_we), 64'd0);
      tick();
    end
    bus.st_valid = 1'b0;
    allow_dual   = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    allow_dual = 1'b0;
    rst_n      = 1'b0;
    idle();

    // Reset, then a single SW
    tick();
    settle();
    chk("rst.st_ready", 64'(bus.st_ready), 64'd0);
    chk("rst.dm_we",    64'(bus.dm_we),    64'd0);
    chk("rst.busy",     64'(bus.busy),     64'd0);
    tick();
    settle();
    chk("rst2.st_ready", 64'(bus.st_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    store(32'h100, 32'hDEADBEEF, 2'b00);
    settle();
    chk("sw.ready", 64'(bus.st_ready), 64'd1);
    chk("sw.we0",   64'(bus.dm_we),    64'd0);
    tick();
    idle();
    settle();
    chk_wr("sw", 32'h100, 32'hDEADBEEF, 2'b00);
    tick();
    settle();
    chk("sw.busy_after", 64'(bus.busy), 64'd0);
    chk("sw.we_after",   64'(bus.dm_we), 64'd0);

    // Fill to full behind a non-matching load
    allow_dual   = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h400;
    for (int i = 0; i < 4; i++) begin
      store(32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 2'b10);
      settle();
      chk($sformatf("fill.ready%0d", i), 64'(bus.st_ready), 64'd1);
      chk($sformatf("fill.we%0d", i), 64'(bus.dm_we), 64'd0);
      tick();
    end
    store(32'h20, 32'hA5, 2'b10);
    settle();
    chk("fill.full_ready", 64'(bus.st_ready), 64'd0);
    chk("fill.stall_none", 64'(bus.ld_stall), 64'd0);
    tick();
    settle();
    chk("fill.fifth_waits", 64'(bus.st_ready), 64'd0);
    bus.st_valid = 1'b0;
    bus.ld_valid = 1'b0;
    allow_dual   = 1'b0;
    settle();
    for (int i = 0; i < 4; i++) begin
      chk_wr($sformatf("fill.d%0d", i), 32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 2'b10);
      tick();
    end
    settle();
    chk("fill.empty", 64'(bus.busy), 64'd0);

    // Load hazard
    allow_dual   = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h400;
    store(32'h200, 32'h11111111, 2'b00);
    tick();
    store(32'h300, 32'h00002222, 2'b01);
    tick();
    bus.st_valid = 1'b0;
    allow_dual   = 1'b0;
    bus.ld_addr  = 32'h202;
    settle();
    chk("haz.stall", 64'(bus.ld_stall), 64'd1);
    chk_wr("haz.d0", 32'h200, 32'h11111111, 2'b00);
    tick();
    settle();
    chk("haz.stall_fall", 64'(bus.ld_stall), 64'd0);
    chk("haz.no_drain",   64'(bus.dm_we),    64'd0);
    chk("haz.busy",       64'(bus.busy),     64'd1);
    tick();
    bus.ld_valid = 1'b0;
    settle();
    chk_wr("haz.d1", 32'h300, 32'h00002222, 2'b01);
    tick();
    settle();
    chk("haz.empty", 64'(bus.busy), 64'd0);

    // Simultaneous push/drain, then pointer wrap
    stream("strm", 8, 32'h500, 32'hC0, 2'b00);
    stream("wrap", 10, 32'h0, 32'h1000, 2'b01);

    // Fence under a non-matching load
    buffer3(32'h600);
    bus.drain_req = 1'b1;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk_wr($sformatf("fence.d%0d", i), 32'h600 + 32'(4 * i), 32'h7000 + 32'(i), 2'b00);
      chk($sformatf("fence.busy%0d", i), 64'(bus.busy), 64'd1);
      tick();
    end
    settle();
    chk("fence.busy_fall", 64'(bus.busy), 64'd0);
    chk("fence.we_off",    64'(bus.dm_we), 64'd0);
    bus.drain_req = 1'b0;
    tick();

    // Fence interrupted by reset after the first drain
    buffer3(32'h700);
    bus.drain_req = 1'b1;
    settle();
    chk_wr("rstmid.d0", 32'h700, 32'h7000, 2'b00);
    tick();
    rst_n = 1'b0;
    settle();
    chk("rstmid.we",    64'(bus.dm_we),    64'd0);
    chk("rstmid.busy",  64'(bus.busy),     64'd0);
    chk("rstmid.ready", 64'(bus.st_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk($sformatf("rstmid.post_we%0d", i), 64'(bus.dm_we), 64'd0);
      chk($sformatf("rstmid.post_busy%0d", i), 64'(bus.busy), 64'd0);
      tick();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_store_buffer.md
Name: mem_store_buffer

Overview:
- Small FIFO write buffer between the EX/MEM pipeline register and the data-memory wrapper (dmem_ultra-style port: we, store size, word address, write data).
- Retires stores from the pipeline in one cycle and drains them to dmem whenever the single memory port is not used by a load.
- Detects load-after-store address hazards and stalls the load until the matching entries have drained.

Parameters:
- DEPTH, 4, number of buffered stores; power of 2, minimum 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- st_valid  in  1  pipeline presents a store this cycle.
- st_addr  in  AW  store byte address.
- st_data  in  DW  store data, unmodified register value.
- st_size  in  2  store size: 00 SW, 01 SH, 10 SB; 11 reserved, treated as SW.
- st_ready  out  1  buffer can accept a store (not full).
- ld_valid  in  1  pipeline presents a load this cycle.
- ld_addr  in  AW  load byte address.
- ld_stall  out  1  load hits a buffered store; pipeline must hold the load.
- drain_req  in  1  fence: drain regardless of loads, with no new pushes expected.
- busy  out  1  buffer non-empty.
- dm_we  out  1  write enable to dmem.
- dm_addr  out  AW  write address to dmem.
- dm_wdata  out  DW  write data to dmem.
- dm_store  out  2  size code to dmem; same encoding as st_size.

Behaviour:
- State:
  - DEPTH entries of {addr, data, size, valid}.
  - head and tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - count register of log2(DEPTH)+1 bits.
- Reset (rst_n=0 at an edge):
  - head=tail=count=0; all valid bits cleared.
  - While rst_n is low, outputs are forced: st_ready=0, dm_we=0, ld_stall=0, busy=0.
  - Reset mid-drain discards all entries; no partial write follows.
- Push:
  - push = st_valid && st_ready; st_ready = (count != DEPTH).
  - On push, the entry is written at tail and tail increments.
  - No full-bypass: a push while full is not accepted, even if a drain occurs that cycle.
- Hazard detection:
  - ld_stall = ld_valid && any valid entry with entry.addr[AW-1:2] == ld_addr[AW-1:2].
  - The compare is conservative, on word address only, with no size/byte-lane check.
  - The compare is combinational, same cycle.
- Drain:
  - drain_en = (count != 0) && (!ld_valid || ld_stall || drain_req).
  - Drain is allowed under a stalled load because the load does not use the port; this prevents deadlock.
  - dm_we = drain_en. dm_addr, dm_wdata and dm_store are taken combinationally from the head entry.
  - On drain, the head valid bit is cleared and head increments.
  - dmem accepts one write per cycle with no backpressure.
- Latency:
  - A store pushed at cycle N appears on dm_we at N+1 at the earliest, when the buffer was empty.
  - Drain is strictly FIFO.
- Simultaneous push and drain: count unchanged; both pointers advance.
- Ordering: after a hazard stall, ld_stall falls in the cycle after the last matching entry drains. The load then reads the updated memory.
- busy = (count != 0), and is used by the fence logic.
- Illegal input: st_valid && ld_valid in the same cycle is illegal for a single-issue pipeline.
  - The bench must assert it never occurs.
  - The RTL accepts the store; the hazard compare excludes the entry being pushed.
- Width rules: no sign or zero extension is done here; size is forwarded unchanged for dmem to apply.

Test Plan:
- Reset then single store:
  - Stimulus: rst_n low for 2 cycles, then SW addr 0x100, data 0xDEADBEEF.
  - Required: st_ready=0 during reset. Next cycle dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, dm_store=00. Then busy=0.
- Fill to full:
  - Stimulus: with ld_valid held high to a non-matching address 0x400, push SB to 0x10, 0x14, 0x18, 0x1C.
  - Required: st_ready=0 after the 4th push, and a 5th store waits. Release ld_valid: four writes drain in FIFO order, dm_store=10 each. count returns to 0.
- Load hazard:
  - Stimulus: buffer SW 0x200 and SH 0x300, then load 0x202.
  - Required: ld_stall=1, and the drain proceeds despite ld_valid. ld_stall=0 the cycle after the entry for 0x200 drains. The load to 0x300 is not flagged.
- Simultaneous push and drain:
  - Stimulus: stream stores every cycle for 8 cycles with no loads.
  - Required: count stays at 1, and each store reaches dm_we exactly one cycle after push.
- Pointer wrap:
  - Stimulus: push and drain 10 stores, addresses 0x0 to 0x24 step 4.
  - Required: all arrive in order with correct data across pointer wrap.
- Fence and mid-operation reset:
  - Stimulus: 3 entries buffered, ld_valid high (non-matching), drain_req=1.
  - Required: drains 1 per cycle; busy falls after 3 cycles.
  - Stimulus: repeat, but pulse rst_n low after the first drain.
  - Required: no further dm_we; busy=0.
